// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one single-port instruction/data memory between
// the fetch stage and the load/store path. Grants one access per eligible
// cycle, tracks the fixed read latency, and steers the read data back to the
// requester that owns the access. A fetch response killed by a redirect or
// flush is dropped. fetch_stall tells the hazard unit when fetch cannot advance.
//
// Optional build macro ARB_PERF_CNT_EN adds two 32-bit performance counters
// (perf_conflict_cnt, perf_stall_cnt). Without it, those ports do not exist.
//
// MEM_LAT must be in 1..4; the latency counter is 3 bits wide.
module fetch_mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    // fetch requester
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    // load/store requester
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    // shared memory port
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    // hazard unit
    output logic                fetch_stall
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_conflict_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = 3;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [STV_W-1:0]   starve_cnt;
    logic               kill_flag;
    logic               owner_dm;   // 1: read in flight belongs to dm, 0: to fetch

    logic active;
    logic resp_cycle;
    logic grant_ok;
    logic starved;
    logic fetch_ok;
    logic fetch_win;
    logic dm_win;
    logic read_gnt;

    // Arbitration decision for the current cycle.
    always_comb begin
        // Every output is forced low while reset is held, even with requests up.
        active     = !rst;
        resp_cycle = (state == WAIT) && (cnt == CNT_W'(MEM_LAT));
        // The response cycle can also launch the next access, so reads issue
        // back to back at one per MEM_LAT cycles.
        grant_ok   = (state == IDLE) || resp_cycle;
        starved    = (starve_cnt == STV_W'(STARVE_MAX));
        // A fetch that is being killed this cycle is never accepted.
        fetch_ok   = if_req && !if_kill;
        fetch_win  = active && grant_ok && fetch_ok && (!dm_req || starved);
        dm_win     = active && grant_ok && dm_req && !fetch_win;
        read_gnt   = fetch_win || (dm_win && !dm_we);
    end

    assign if_gnt  = fetch_win;
    assign dm_gnt  = dm_win;
    assign mem_en  = fetch_win || dm_win;
    assign mem_we  = dm_win && dm_we;
    assign mem_addr = dm_win ? dm_addr : (fetch_win ? if_addr : '0);

    // Write data and byte enables come only from the data side; a fetch is
    // a plain read, so its lanes are driven low.
    genvar gi;
    generate
        for (gi = 0; gi < BE_W; gi++) begin : g_lane
            assign mem_wdata[gi*8 +: 8] = dm_win ? dm_wdata[gi*8 +: 8] : 8'h00;
            assign mem_be[gi]           = dm_win && dm_be[gi];
        end
    endgenerate

    // A kill seen in the response cycle itself still suppresses that response.
    assign if_rvalid   = active && resp_cycle && !owner_dm && !kill_flag && !if_kill;
    assign dm_rvalid   = active && resp_cycle && owner_dm;
    assign if_rdata    = if_rvalid ? mem_rdata : '0;
    assign dm_rdata    = dm_rvalid ? mem_rdata : '0;
    assign fetch_stall = active && if_req && !if_rvalid;

    // Read-tracking FSM together with its owner, kill and starvation state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            starve_cnt <= '0;
            kill_flag  <= 1'b0;
            owner_dm   <= 1'b0;
        end else begin
            // The kill flag belongs to the fetch currently in flight and is
            // retired together with its response.
            if (resp_cycle) begin
                kill_flag <= 1'b0;
            end else if ((state == WAIT) && !owner_dm && if_kill) begin
                kill_flag <= 1'b1;
            end

            if (read_gnt) begin
                state    <= WAIT;
                cnt      <= CNT_W'(1);
                owner_dm <= dm_win;
            end else if (resp_cycle) begin
                state    <= IDLE;
                cnt      <= '0;
                owner_dm <= 1'b0;
            end else if (state == WAIT) begin
                cnt <= cnt + CNT_W'(1);
            end

            // Count consecutive fetch losses to dm; any fetch grant resets it.
            if (fetch_win) begin
                starve_cnt <= '0;
            end else if (dm_win && if_req && !starved) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    // Free-running, wrapping counts of contended grants and fetch stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_conflict_cnt <= '0;
            perf_stall_cnt    <= '0;
        end else begin
            if (mem_en && if_req && dm_req) begin
                perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
            end
            if (fetch_stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter: random requesters plus a behavioural memory drive the
// arbiter; a transaction-level reference model (one pending read with a due
// cycle, a word-addressed memory image, a starvation tally) predicts every
// grant, response and stall. Build macro ARB_PERF_CNT_EN also checks the
// performance counters.
`timescale 1ns/1ps
module tb_fetch_mem_arbiter;

    localparam int ADDR_W     = 64;
    localparam int DATA_W     = 32;
    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
    localparam int BE_W       = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_kill = 1'b0;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req = 1'b0;
    logic              dm_we = 1'b0;
    logic [ADDR_W-1:0] dm_addr = '0;
    logic [DATA_W-1:0] dm_wdata = '0;
    logic [BE_W-1:0]   dm_be = '0;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              fetch_stall;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]       perf_conflict_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    fetch_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata),
        .fetch_stall(fetch_stall)
`ifdef ARB_PERF_CNT_EN
        , .perf_conflict_cnt(perf_conflict_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Single comparison point for the whole bench.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state: at most one read outstanding, due at a given cycle.
    bit                pend_v = 1'b0;
    bit                pend_dm = 1'b0;
    bit                pend_kill = 1'b0;
    int                pend_due = 0;
    logic [DATA_W-1:0] pend_data = '0;
    int                starve = 0;
    logic [DATA_W-1:0] model_mem [logic [ADDR_W-1:0]];
    bit                last_if_gnt = 1'b0;
    bit                last_dm_gnt = 1'b0;
    bit                last_read_gnt = 1'b0;
    longint            exp_conflict = 0;
    longint            exp_stall = 0;

    // Behavioural memory that answers whatever the DUT actually drives.
    logic [DATA_W-1:0] phys_mem [logic [ADDR_W-1:0]];
    bit                pipe_v [8];
    logic [DATA_W-1:0] pipe_d [8];

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                                input logic [DATA_W-1:0] new_w,
                                                input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] w;
        w = old_w;
        for (int b = 0; b < BE_W; b++) if (be[b]) w[b*8 +: 8] = new_w[b*8 +: 8];
        return w;
    endfunction

    function automatic logic [DATA_W-1:0] rd_model(input logic [ADDR_W-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_word(a);
    endfunction

    function automatic logic [DATA_W-1:0] rd_phys(input logic [ADDR_W-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [ADDR_W-1:0] rand_addr();
        logic [ADDR_W-1:0] a;
        a = ADDR_W'($urandom_range(15)) << 2;
        if ($urandom_range(7) == 0) a[63:32] = $urandom();
        return a;
    endfunction

    // One clock cycle: drive memory data, compare outputs with the model, advance.
    task automatic step();
        bit resp, elig, f_ok, f_win, d_win, e_ifv, e_dmv, e_stall;
        int slot;
        slot = cyc % 8;
        mem_rdata = pipe_v[slot] ? pipe_d[slot] : DATA_W'($urandom());
        pipe_v[slot] = 1'b0;
        #1;
        if (rst) begin
            chk("rst_if_gnt", if_gnt, 0);
            chk("rst_dm_gnt", dm_gnt, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_if_rvalid", if_rvalid, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_dm_rvalid", dm_rvalid, 0);
            chk("rst_dm_rdata", dm_rdata, 0);
            chk("rst_fetch_stall", fetch_stall, 0);
            pend_v = 1'b0;
            pend_kill = 1'b0;
            starve = 0;
            last_if_gnt = 1'b0;
            last_dm_gnt = 1'b0;
            last_read_gnt = 1'b0;
            exp_conflict = 0;
            exp_stall = 0;
        end else begin
            resp  = pend_v && (pend_due == cyc);
            elig  = !pend_v || resp;
            e_ifv = resp && !pend_dm && !pend_kill && !if_kill;
            e_dmv = resp && pend_dm;
            f_ok  = if_req && !if_kill;
            f_win = elig && f_ok && (!dm_req || starve == STARVE_MAX);
            d_win = elig && dm_req && !f_win;
            e_stall = if_req && !e_ifv;

            chk("if_gnt", if_gnt, f_win);
            chk("dm_gnt", dm_gnt, d_win);
            chk("mem_en", mem_en, f_win || d_win);
            chk("mem_we", mem_we, d_win && dm_we);
            chk("if_rvalid", if_rvalid, e_ifv);
            chk("if_rdata", if_rdata, e_ifv ? pend_data : '0);
            chk("dm_rvalid", dm_rvalid, e_dmv);
            chk("dm_rdata", dm_rdata, e_dmv ? pend_data : '0);
            chk("fetch_stall", fetch_stall, e_stall);
            if (f_win) chk("mem_addr_if", mem_addr, if_addr);
            if (d_win) begin
                chk("mem_addr_dm", mem_addr, dm_addr);
                chk("mem_be", mem_be, dm_be);
                if (dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
            end

            if ((f_win || d_win) && if_req && dm_req) exp_conflict++;
            if (e_stall) exp_stall++;

            if (pend_v && !pend_dm && if_kill) pend_kill = 1'b1;
            if (resp) pend_v = 1'b0;
            if (f_win || (d_win && !dm_we)) begin
                pend_v    = 1'b1;
                pend_dm   = d_win;
                pend_kill = 1'b0;
                pend_due  = cyc + MEM_LAT;
                pend_data = rd_model(d_win ? dm_addr : if_addr);
            end
            if (d_win && dm_we) model_mem[dm_addr] = merge(rd_model(dm_addr), dm_wdata, dm_be);

            if (f_win) starve = 0;
            else if (d_win && if_req && starve < STARVE_MAX) starve++;

            if (f_win) $display("cycle %0d: fetch read  addr 0x%0h", cyc, if_addr);
            if (d_win) $display("cycle %0d: dm %s addr 0x%0h wdata 0x%0h be 0x%0h",
                                cyc, dm_we ? "write" : "read ", dm_addr, dm_wdata, dm_be);
            last_if_gnt   = f_win;
            last_dm_gnt   = d_win;
            last_read_gnt = f_win || (d_win && !dm_we);
        end
        if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) begin
                phys_mem[mem_addr] = merge(rd_phys(mem_addr), mem_wdata, mem_be);
            end else begin
                pipe_v[(cyc + MEM_LAT) % 8] = 1'b1;
                pipe_d[(cyc + MEM_LAT) % 8] = rd_phys(mem_addr);
            end
        end
        cyc++;
    endtask

    // Random requesters: hold a request until granted, occasionally withdraw it.
    task automatic drive(input int p_if, input int p_dm, input int p_kill, input int p_we);
        if (!if_req || last_if_gnt) begin
            if_req  = ($urandom_range(99) < p_if);
            if_addr = rand_addr();
        end else if ($urandom_range(99) < 3) begin
            if_req = 1'b0;
        end
        if (!dm_req || last_dm_gnt) begin
            dm_req   = ($urandom_range(99) < p_dm);
            dm_we    = ($urandom_range(99) < p_we);
            dm_addr  = rand_addr();
            dm_wdata = DATA_W'($urandom());
            dm_be    = BE_W'($urandom_range(15));
        end else if ($urandom_range(99) < 3) begin
            dm_req = 1'b0;
        end
        if_kill = ($urandom_range(99) < p_kill);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 8; i++) pipe_v[i] = 1'b0;

        // Reset held with both requests up: every output must stay low.
        if_req = 1'b1;
        dm_req = 1'b1;
        repeat (2) begin @(negedge clk); step(); end
        @(negedge clk);
        rst = 1'b0;
        if_req = 1'b0;
        dm_req = 1'b0;
        step();

        // Balanced traffic, then heavy contention, then kill-heavy fetch traffic.
        for (int i = 0; i < 300; i++) begin @(negedge clk); drive(50, 50, 10, 30); step(); end
        for (int i = 0; i < 300; i++) begin @(negedge clk); drive(95, 95, 3, 20); step(); end
        for (int i = 0; i < 300; i++) begin @(negedge clk); drive(70, 30, 30, 40); step(); end

        // Reset in the cycle after a read grant abandons that read.
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk); drive(60, 60, 5, 30); step(); seen = last_read_gnt;
        end
        chk("read_grant_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; if_kill = 1'b0;
        step();
        @(negedge clk); step();
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0;
        step();
        repeat (4) begin @(negedge clk); step(); end

        // A fresh fetch after the reset completes normally.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); if_req = 1'b1; if_addr = 64'h40; step();
        end
        @(negedge clk); if_req = 1'b0; step();

`ifdef ARB_PERF_CNT_EN
        @(negedge clk);
        chk("perf_conflict_cnt", perf_conflict_cnt, 64'(exp_conflict[31:0]));
        chk("perf_stall_cnt", perf_stall_cnt, 64'(exp_stall[31:0]));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
Arbitrates one shared single-port instruction/data memory between the fetch stage and the load/store path.
- Grants one access at a time.
- Tracks the fixed read latency and returns read data to the owning requester.
- Drops fetch responses killed by a redirect or flush.
- Produces fetch_stall, which the hazard unit uses to deassert PCWriteF and IF_IDWriteF.

Parameters:
ADDR_W, 64, address width of both requesters and the memory port
DATA_W, 32, memory word width
MEM_LAT, 2, memory read latency in cycles; legal range 1..4
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win

Ports:
clk  in  1  clock
rst  in  1  reset
if_req  in  1  fetch read request; held until if_gnt
if_addr  in  ADDR_W  fetch address (PCF)
if_kill  in  1  redirect/flush; discard any in-flight fetch response
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  fetch read data valid
if_rdata  out  DATA_W  fetch read data
dm_req  in  1  data request; held until dm_gnt
dm_we  in  1  1 = write, 0 = read
dm_addr  in  ADDR_W  data address
dm_wdata  in  DATA_W  write data
dm_be  in  DATA_W/8  byte enables
dm_gnt  out  1  data request accepted this cycle
dm_rvalid  out  1  data read data valid
dm_rdata  out  DATA_W  data read data
mem_en  out  1  memory access strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  DATA_W/8  memory byte enables
mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
fetch_stall  out  1  fetch cannot advance this cycle

Behaviour:
Reset:
- rst is asynchronous, active-high; clk is the clock.
- On reset: state IDLE, latency counter 0, starve_cnt 0, kill flag 0, owner cleared.
- All outputs are 0 during reset.
- Reset mid-transaction abandons the access; no rvalid appears after reset is released.

States:
- IDLE: no read in flight.
- WAIT: read in flight; cnt counts 1..MEM_LAT.

Grant-eligible cycle:
- Either IDLE, or WAIT with cnt==MEM_LAT (the response cycle). This allows back-to-back reads, one per MEM_LAT cycles.

Grant cycle T:
- Exactly one gnt pulses.
- mem_en=1; mem_addr/mem_we/mem_wdata/mem_be are driven combinationally from the winner.
- Outside grant cycles, mem_en=0 and mem_we=0.

Read grant:
- Enter WAIT with cnt=1; record owner.
- At cnt==MEM_LAT, the owner's rvalid=1 and rdata=mem_rdata.
- Return to IDLE unless a new read is granted in the same cycle.

Write grant:
- Completes in cycle T; no rvalid.
- FSM stays IDLE, so the next grant is possible at T+1.

Arbitration:
- dm wins by default.
- Fetch wins if starve_cnt==STARVE_MAX, or if dm_req=0.
- starve_cnt increments (saturating) each time if_req=1 and dm is granted; it clears on any if_gnt.

if_kill:
- In the grant cycle: fetch is not granted that cycle.
- While a fetch is in flight (any WAIT cycle, including the response cycle): set the kill flag; if_rvalid is suppressed for that response. The flag clears at the response cycle.
- While a dm access is in flight, or in IDLE with no fetch pending: no effect.

fetch_stall:
- fetch_stall = if_req & ~if_rvalid.
- It is combinational, so it is high in the grant cycle and in every wait cycle.

Other rules:
- rdata outputs are 0 when their rvalid=0.
- Addresses pass through unmodified; alignment is not checked.
- Requesters may drop a request before gnt. After gnt, the arbiter ignores changes to request inputs.

Optional Feature:
Macro ARB_PERF_CNT_EN.
- Defined: adds outputs perf_conflict_cnt (32) and perf_stall_cnt (32). Both reset to 0 and wrap at 2^32.
  - perf_conflict_cnt increments in every grant cycle where both requests are present.
  - perf_stall_cnt increments every cycle fetch_stall=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. MEM_LAT=2; lone fetch, if_addr=0x40; mem_rdata=0x00000013 at T+2:
   - if_gnt and mem_en at T, with mem_addr=0x40.
   - if_rvalid=1 and if_rdata=0x00000013 at T+2.
   - fetch_stall=1 at T and T+1, 0 at T+2.
2. Simultaneous dm read 0x100 and fetch 0x44:
   - dm_gnt at T; dm_rvalid at T+2.
   - if_gnt at T+2; if_rvalid at T+4.
3. STARVE_MAX=4; dm_req held as continuous reads, if_req held:
   - dm wins 4 grant opportunities; fetch wins the 5th.
   - starve_cnt returns to 0.
4. Fetch 0x48 granted at T; if_kill pulsed at T+1:
   - No if_rvalid at T+2.
   - New fetch 0x200 presented at T+2 is granted at T+2; its if_rvalid is at T+4.
5. dm write 0x80, data 0xDEADBEEF, be 0xF, with if_req:
   - mem_we=1 and dm_gnt at T; no dm_rvalid.
   - if_gnt at T+1.
6. rst asserted at T+1 during a read granted at T:
   - All outputs 0 immediately.
   - No rvalid after release.
   - A new fetch after release completes normally.
